// File: rtl/sr_bank_pkg.sv
// Shared opcode and control-state encodings for the SR bank arbiter.
package sr_bank_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_TOG  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    LOCKED = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/sr_cell.sv
// One synchronous set/reset storage cell; s=r=0 holds, s sets, r clears.
module sr_cell (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)  q <= 1'b0;
    else if (s) q <= 1'b1;
    else if (r) q <= 1'b0;
  end

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter feeding a bank of SR cells through a one-deep command register.
// Optional grant locking is enabled by defining SR_ARB_LOCK_EN.
module sr_bank_arbiter
  import sr_bank_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [IDXW*N_REQ-1:0]  idx,
`ifdef SR_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       lock,
`endif
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic                   err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  ctrl_state_t     state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   pos;
  logic [PW-1:0]   next_ptr;
  logic            found;
  logic            locking;
  logic [1:0]      sel_op;
  logic [IDXW-1:0] sel_idx;
  logic            sel_lock;
  op_t             pend_op;
  logic [IDXW-1:0] pend_idx;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
`ifdef SR_ARB_LOCK_EN
  logic [PW-1:0]   owner;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = PW'((int'(ptr) + k) % N_REQ);
      if (!found && req[pos]) begin
        found = 1'b1;
        win   = pos;
      end
    end
`ifdef SR_ARB_LOCK_EN
    if (state == LOCKED) begin
      found = req[owner];
      win   = owner;
    end
`endif
    if (reset) found = 1'b0;
  end

  assign gnt = found ? (N_REQ'(1) << win) : '0;

  always_comb begin
    sel_op   = '0;
    sel_idx  = '0;
    sel_lock = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == PW'(k)) begin
        sel_op  = op[2*k +: 2];
        sel_idx = idx[IDXW*k +: IDXW];
`ifdef SR_ARB_LOCK_EN
        sel_lock = lock[k];
`endif
      end
    end
  end

  assign locking  = found & sel_lock;
  assign next_ptr = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
  assign busy     = (state != IDLE);

  // Only the addressed cell sees a drive; TOGGLE derives S/R from q so S=R=1 cannot occur.
  always_comb begin
    s = '0;
    r = '0;
    for (int c = 0; c < WIDTH; c++) begin
      if (busy && int'(pend_idx) == c) begin
        case (pend_op)
          OP_SET:  s[c] = 1'b1;
          OP_CLR:  r[c] = 1'b1;
          OP_TOG: begin
            s[c] = ~q[c];
            r[c] = q[c];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      err      <= 1'b0;
      pend_op  <= OP_HOLD;
      pend_idx <= '0;
`ifdef SR_ARB_LOCK_EN
      owner    <= '0;
`endif
    end else begin
      if (busy && int'(pend_idx) >= WIDTH) err <= 1'b1;
      if (found) begin
        pend_op  <= op_t'(sel_op);
        pend_idx <= sel_idx;
      end
      if (locking) begin
        state <= LOCKED;
`ifdef SR_ARB_LOCK_EN
        owner <= win;
`endif
      end else if (found) begin
        state <= ISSUE;
        ptr   <= next_ptr;
      end else begin
        state <= IDLE;
      end
    end
  end

  for (genvar c = 0; c < WIDTH; c++) begin : g_cell
    sr_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .s     (s[c]),
      .r     (r[c]),
      .q     (q[c])
    );
  end

  a_no_set_and_reset: assert property (@(posedge clk) disable iff (reset) (s & r) == '0);

endmodule
